vending_controller_param: RTL and testbench

//   Parametrised coin-operated vending controller, successor to the fixed-price FSM.
//   - Accumulates nickel/dime/quarter credit up to a programmable PRICE.
//   - Issues a vend request with a valid/ready handshake.
//   - Returns change as a sequence of greedy coin handshakes.
//   - Counts completed sales.

---
 rtl/vm_pkg.sv | 18 +
 rtl/vm_if.sv | 41 ++++
 rtl/vm_change_select.sv | 24 ++
 rtl/vending_controller_param.sv | 114 +++++++++++
 tb/tb_vending_controller_param.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NICKLE  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;

  localparam int VAL_NICKLE  = 1;
  localparam int VAL_DIME    = 2;
  localparam int VAL_QUARTER = 5;

endpackage

// File: rtl/vm_if.sv
// Coin, vend and change-hopper signal bundle for vending_controller_param.
// i_refund exists only when VM_REFUND_EN is defined.
interface vm_if #(
  parameter int CREDIT_W = 4,
  parameter int SALES_W  = 8
) ();

  logic                i_nickle;
  logic                i_dime;
  logic                i_quarter;
  logic                i_vend_ready;
  logic                i_change_ready;
`ifdef VM_REFUND_EN
  logic                i_refund;
`endif
  logic [CREDIT_W-1:0] o_credit;
  logic                o_vend_valid;
  logic                o_change_valid;
  logic [1:0]          o_change_coin;
  logic                o_coin_reject;
  logic [SALES_W-1:0]  o_sales_cnt;

  modport master (
    output i_nickle, i_dime, i_quarter, i_vend_ready, i_change_ready,
`ifdef VM_REFUND_EN
    output i_refund,
`endif
    input  o_credit, o_vend_valid, o_change_valid, o_change_coin,
    input  o_coin_reject, o_sales_cnt
  );

  modport slave (
    input  i_nickle, i_dime, i_quarter, i_vend_ready, i_change_ready,
`ifdef VM_REFUND_EN
    input  i_refund,
`endif
    output o_credit, o_vend_valid, o_change_valid, o_change_coin,
    output o_coin_reject, o_sales_cnt
  );

endinterface

// File: rtl/vm_change_select.sv
// Greedy change picker: largest coin not exceeding the remaining credit.
module vm_change_select
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [CREDIT_W-1:0] o_value
);

  always_comb begin
    o_coin  = COIN_NICKLE;
    o_value = CREDIT_W'(VAL_NICKLE);
    if (i_credit >= CREDIT_W'(VAL_QUARTER)) begin
      o_coin  = COIN_QUARTER;
      o_value = CREDIT_W'(VAL_QUARTER);
    end else if (i_credit >= CREDIT_W'(VAL_DIME)) begin
      o_coin  = COIN_DIME;
      o_value = CREDIT_W'(VAL_DIME);
    end
  end

endmodule

// File: rtl/vending_controller_param.sv
// Parametrised coin vending controller: collect credit, vend handshake, greedy change.
// Optional refund path enabled by defining VM_REFUND_EN.
module vending_controller_param
  import vm_pkg::*;
#(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 4,
  parameter int SALES_W  = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  vm_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  generate
    if (PRICE < 1 || (2**CREDIT_W - 1) < (PRICE + 4)) begin : g_bad_params
      $error("vending_controller_param: PRICE/CREDIT_W combination can overflow credit");
    end
  endgenerate

  state_t              r_state;
  state_t              w_nextState;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_nextCredit;
  logic [SALES_W-1:0]  r_salesCnt;
  logic                r_reject;
  logic                w_reject;
  logic                w_sale;
  logic                w_anyCoin;
  logic                w_multiCoin;
  logic [CREDIT_W-1:0] w_coinValue;
  logic [1:0]          w_changeCoin;
  logic [CREDIT_W-1:0] w_changeValue;

  vm_change_select #(.CREDIT_W(CREDIT_W)) u_change_select (
    .i_credit (r_credit),
    .o_coin   (w_changeCoin),
    .o_value  (w_changeValue)
  );

  assign w_anyCoin   = bus.i_nickle | bus.i_dime | bus.i_quarter;
  assign w_multiCoin = (bus.i_nickle & bus.i_dime) | (bus.i_nickle & bus.i_quarter) |
                       (bus.i_dime & bus.i_quarter);
  // Priority nickel > dime > quarter; losers are reported via o_coin_reject.
  assign w_coinValue = bus.i_nickle  ? CREDIT_W'(VAL_NICKLE)  :
                       bus.i_dime    ? CREDIT_W'(VAL_DIME)    :
                       bus.i_quarter ? CREDIT_W'(VAL_QUARTER) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= COLLECT;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_credit   <= '0;
      r_salesCnt <= '0;
      r_reject   <= 1'b0;
    end else begin
      r_credit <= w_nextCredit;
      r_reject <= w_reject;
      if (w_sale && (r_salesCnt != '1)) r_salesCnt <= r_salesCnt + 1'b1;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextCredit = r_credit;
    w_reject     = 1'b0;
    w_sale       = 1'b0;
    case (r_state)
      COLLECT: begin
        w_reject = w_multiCoin;
        if (w_anyCoin) begin
          w_nextCredit = r_credit + w_coinValue;
          if (w_nextCredit >= PRICE_C) w_nextState = VEND;
        end
`ifdef VM_REFUND_EN
        else if (bus.i_refund && (r_credit != '0)) begin
          w_nextState = CHANGE;
        end
`endif
      end
      VEND: begin
        w_reject = w_anyCoin;
        if (bus.i_vend_ready) begin
          w_nextCredit = r_credit - PRICE_C;
          w_sale       = 1'b1;
          w_nextState  = (w_nextCredit != '0) ? CHANGE : COLLECT;
        end
      end
      CHANGE: begin
        w_reject = w_anyCoin;
        if (bus.i_change_ready) begin
          w_nextCredit = r_credit - w_changeValue;
          if (w_nextCredit == '0) w_nextState = COLLECT;
        end
      end
      default: w_nextState = COLLECT;
    endcase
  end

  always_comb begin
    bus.o_credit       = r_credit;
    bus.o_vend_valid   = (r_state == VEND);
    bus.o_change_valid = (r_state == CHANGE);
    bus.o_change_coin  = (r_state == CHANGE) ? w_changeCoin : COIN_NICKLE;
    bus.o_coin_reject  = r_reject;
    bus.o_sales_cnt    = r_salesCnt;
  end

endmodule

// File: tb/tb_vending_controller_param.sv
// Directed self-checking bench for vending_controller_param (PRICE=4, CREDIT_W=4, SALES_W=8).
module tb_vending_controller_param;

  logic i_clk;
  logic i_rst;
  int   compareCount;
  int   failCount;

  vm_if #(.CREDIT_W(4), .SALES_W(8)) bus ();

  vending_controller_param #(.PRICE(4), .CREDIT_W(4), .SALES_W(8)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Inputs change and outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic applyStimulus(input logic n, input logic d, input logic q);
    bus.i_nickle  = n;
    bus.i_dime    = d;
    bus.i_quarter = q;
    @(negedge i_clk);
    bus.i_nickle  = 1'b0;
    bus.i_dime    = 1'b0;
    bus.i_quarter = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [31:0] expSales);
    checkOutput({tag, " credit"},       32'(bus.o_credit), 32'd0);
    checkOutput({tag, " vend_valid"},   32'(bus.o_vend_valid), 32'd0);
    checkOutput({tag, " change_valid"}, 32'(bus.o_change_valid), 32'd0);
    checkOutput({tag, " change_coin"},  32'(bus.o_change_coin), 32'd0);
    checkOutput({tag, " coin_reject"},  32'(bus.o_coin_reject), 32'd0);
    checkOutput({tag, " sales_cnt"},    32'(bus.o_sales_cnt), expSales);
  endtask

  initial begin
    compareCount = 0;
    failCount    = 0;
    i_rst              = 1'b1;
    bus.i_nickle       = 1'b0;
    bus.i_dime         = 1'b0;
    bus.i_quarter      = 1'b0;
    bus.i_vend_ready   = 1'b0;
    bus.i_change_ready = 1'b0;
`ifdef VM_REFUND_EN
    bus.i_refund       = 1'b0;
`endif
    tick();
    tick();
    checkIdle("reset", 32'd0);
    i_rst = 1'b0;

    // Four nickels with the dispenser always ready.
    bus.i_vend_ready = 1'b1;
    applyStimulus(1, 0, 0);
    checkOutput("n1 credit", 32'(bus.o_credit), 32'd1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("n3 credit", 32'(bus.o_credit), 32'd3);
    checkOutput("n3 vend_valid", 32'(bus.o_vend_valid), 32'd0);
    applyStimulus(1, 0, 0);
    checkOutput("n4 vend_valid", 32'(bus.o_vend_valid), 32'd1);
    checkOutput("n4 credit", 32'(bus.o_credit), 32'd4);
    tick();
    checkIdle("after vend1", 32'd1);

    // dime + nickel + quarter = 8, vend 4, change dime then dime.
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    checkOutput("dn credit", 32'(bus.o_credit), 32'd3);
    applyStimulus(0, 0, 1);
    checkOutput("dnq credit", 32'(bus.o_credit), 32'd8);
    checkOutput("dnq vend_valid", 32'(bus.o_vend_valid), 32'd1);
    tick();
    checkOutput("chg1 credit", 32'(bus.o_credit), 32'd4);
    checkOutput("chg1 valid", 32'(bus.o_change_valid), 32'd1);
    checkOutput("chg1 coin", 32'(bus.o_change_coin), 32'd1);
    checkOutput("chg1 sales", 32'(bus.o_sales_cnt), 32'd2);
    checkOutput("chg1 vend_valid", 32'(bus.o_vend_valid), 32'd0);
    tick();
    checkOutput("chg1 hold credit", 32'(bus.o_credit), 32'd4);
    checkOutput("chg1 hold valid", 32'(bus.o_change_valid), 32'd1);
    bus.i_change_ready = 1'b1;
    tick();
    checkOutput("chg2 credit", 32'(bus.o_credit), 32'd2);
    checkOutput("chg2 coin", 32'(bus.o_change_coin), 32'd1);
    checkOutput("chg2 valid", 32'(bus.o_change_valid), 32'd1);
    tick();
    bus.i_change_ready = 1'b0;
    checkIdle("after change", 32'd2);

    // Quarter with the dispenser stalled; a dime during VEND is rejected.
    bus.i_vend_ready = 1'b0;
    applyStimulus(0, 0, 1);
    checkOutput("stall credit", 32'(bus.o_credit), 32'd5);
    checkOutput("stall vend_valid", 32'(bus.o_vend_valid), 32'd1);
    tick();
    tick();
    checkOutput("stall2 vend_valid", 32'(bus.o_vend_valid), 32'd1);
    applyStimulus(0, 1, 0);
    checkOutput("stall dime reject", 32'(bus.o_coin_reject), 32'd1);
    checkOutput("stall dime credit", 32'(bus.o_credit), 32'd5);
    checkOutput("stall dime vend_valid", 32'(bus.o_vend_valid), 32'd1);
    tick();
    checkOutput("stall reject clear", 32'(bus.o_coin_reject), 32'd0);
    checkOutput("stall4 vend_valid", 32'(bus.o_vend_valid), 32'd1);
    tick();
    bus.i_vend_ready = 1'b1;
    tick();
    bus.i_vend_ready = 1'b0;
    checkOutput("stall chg credit", 32'(bus.o_credit), 32'd1);
    checkOutput("stall chg valid", 32'(bus.o_change_valid), 32'd1);
    checkOutput("stall chg coin", 32'(bus.o_change_coin), 32'd0);
    checkOutput("stall chg sales", 32'(bus.o_sales_cnt), 32'd3);
    bus.i_change_ready = 1'b1;
    tick();
    bus.i_change_ready = 1'b0;
    checkIdle("after stall", 32'd3);

    // Simultaneous coins: highest priority credited, the rest rejected.
    applyStimulus(1, 0, 1);
    checkOutput("nq credit", 32'(bus.o_credit), 32'd1);
    checkOutput("nq reject", 32'(bus.o_coin_reject), 32'd1);
    tick();
    checkOutput("nq reject clear", 32'(bus.o_coin_reject), 32'd0);
    applyStimulus(0, 1, 1);
    checkOutput("dq credit", 32'(bus.o_credit), 32'd3);
    checkOutput("dq reject", 32'(bus.o_coin_reject), 32'd1);

    // Reach CHANGE with the hopper stalled, then reset asynchronously.
    bus.i_vend_ready = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("pre-rst credit", 32'(bus.o_credit), 32'd8);
    tick();
    bus.i_vend_ready = 1'b0;
    checkOutput("pre-rst change_valid", 32'(bus.o_change_valid), 32'd1);
    checkOutput("pre-rst sales", 32'(bus.o_sales_cnt), 32'd4);
    #2 i_rst = 1'b1;
    #1;
    checkIdle("async rst", 32'd0);
    tick();
    i_rst = 1'b0;

`ifdef VM_REFUND_EN
    // Refund with zero credit is ignored; with credit it returns dime then nickel.
    bus.i_refund = 1'b1;
    tick();
    bus.i_refund = 1'b0;
    checkOutput("refund0 change_valid", 32'(bus.o_change_valid), 32'd0);
    applyStimulus(0, 1, 0);
    applyStimulus(1, 0, 0);
    bus.i_refund = 1'b1;
    tick();
    bus.i_refund = 1'b0;
    checkOutput("refund coin1", 32'(bus.o_change_coin), 32'd1);
    checkOutput("refund valid1", 32'(bus.o_change_valid), 32'd1);
    bus.i_change_ready = 1'b1;
    tick();
    checkOutput("refund coin2", 32'(bus.o_change_coin), 32'd0);
    checkOutput("refund credit2", 32'(bus.o_credit), 32'd1);
    tick();
    bus.i_change_ready = 1'b0;
    checkIdle("after refund", 32'd0);
`endif

    // 256 vends drive the 8-bit sales counter into saturation.
    bus.i_vend_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      for (int c = 0; c < 4; c++) applyStimulus(1, 0, 0);
      tick();
    end
    bus.i_vend_ready = 1'b0;
    checkIdle("saturate", 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
